risco5_io_bridge: RTL and testbench

//  Parametrised byte-serial bridge between the core's memory-request bus and the

---
 rtl/risco5_io_pkg.sv | 8 +
 rtl/risco5_io_bridge_if.sv | 23 ++
 rtl/risco5_io_shifter.sv | 39 +++
 rtl/risco5_io_bridge.sv | 138 +++++++++++++
 tb/tb_risco5_io_bridge.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/risco5_io_pkg.sv
// risco5_io_pkg: shared types and constants for the byte-serial pad bridge
package risco5_io_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, TURN, RDATA, RESP} state_t;
  localparam int CMD_WE_BIT = 7;
  localparam int CMD_STRB_LSB = 0;
  localparam logic [7:0] PAD_OE_OUT = 8'hFF;
  localparam int CNT_W = 8;
endpackage

// File: rtl/risco5_io_bridge_if.sv
// risco5_io_bridge_if: core memory-request/response bus between core (master) and bridge (slave)
interface risco5_io_bridge_if #(
  parameter int ADDR_W = 24,
  parameter int WORD_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [WORD_W/8-1:0] req_wstrb;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/risco5_io_shifter.sv
// risco5_io_shifter: byte serialiser (LSB byte out first) / deserialiser (bytes enter at the top) with byte counter
module risco5_io_shifter
  import risco5_io_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     ld_data,
  input  logic [CNT_W-1:0] ld_cnt,
  input  logic             shift,
  input  logic             capture,
  input  logic [7:0]       cap_byte,
  output logic [7:0]       byte_out,
  output logic [W-1:0]     data,
  output logic             last
);
  logic [W-1:0]     sr;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= ld_data;
      cnt <= ld_cnt;
    end else if (shift) begin
      sr  <= sr >> 8;
      cnt <= cnt - 1'b1;
    end else if (capture) begin
      sr  <= {cap_byte, sr[W-1:8]};
      cnt <= cnt - 1'b1;
    end
  end
  assign byte_out = sr[7:0];
  assign data = sr;
  assign last = cnt == '0;
endmodule

// File: rtl/risco5_io_bridge.sv
// risco5_io_bridge: serialises core requests onto the 8-bit uio pads under strobe/ack.
// Optional ack timeout with error response when RISCO5_IO_TIMEOUT_EN is defined.
module risco5_io_bridge
  import risco5_io_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int WORD_W = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  risco5_io_bridge_if.slave   bus,
  output logic [7:0]          pad_out,
  output logic [7:0]          pad_oe,
  input  logic [7:0]          pad_in,
  output logic                pad_strobe,
  input  logic                pad_ack,
  output logic                busy
);
  localparam int SW = ADDR_W > WORD_W ? ADDR_W : WORD_W;
  state_t            state, state_d;
  logic              we_q;
  logic [3:0]        strb_q;
  logic [ADDR_W-1:0] addr_q, addr_rev;
  logic [WORD_W-1:0] wdata_q;
  logic              accept, xfer, oe_on, to_err;
  logic [7:0]        cmd_byte, sh_byte;
  logic              sh_load, sh_shift, sh_cap, sh_last;
  logic [SW-1:0]     sh_ld_data, sh_data;
  logic [CNT_W-1:0]  sh_ld_cnt;
  assign accept = state == IDLE && bus.req_valid;
  assign xfer = pad_strobe && pad_ack;
  // address leaves MSB byte first, so the shifter gets it byte-reversed
  for (genvar i = 0; i < ADDR_W/8; i++) begin : g_rev
    assign addr_rev[8*i +: 8] = addr_q[ADDR_W-8-8*i +: 8];
  end
  assign cmd_byte = (8'(we_q) << CMD_WE_BIT) | (8'(we_q ? strb_q : 4'h0) << CMD_STRB_LSB);
`ifdef RISCO5_IO_TIMEOUT_EN
  logic [31:0] tcnt;
  logic        err_q, timeout;
  assign timeout = pad_strobe && !pad_ack && tcnt == 32'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt  <= (accept || xfer) ? '0 : pad_strobe ? tcnt + 1 : tcnt;
      err_q <= accept ? 1'b0 : timeout ? 1'b1 : err_q;
    end
  end
  assign to_err = err_q;
`else
  assign to_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      strb_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        strb_q  <= 4'(bus.req_wstrb);
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
    end
  end
  always_comb begin
    state_d    = state;
    sh_load    = 1'b0;
    sh_ld_data = '0;
    sh_ld_cnt  = '0;
    sh_shift   = 1'b0;
    sh_cap     = 1'b0;
    case (state)
      IDLE:  if (bus.req_valid) state_d = CMD;
      CMD:   if (xfer) begin
               sh_load    = 1'b1;
               sh_ld_data = SW'(addr_rev);
               sh_ld_cnt  = CNT_W'(ADDR_W/8 - 1);
               state_d    = ADDR;
             end
      ADDR:  if (xfer) begin
               sh_shift = 1'b1;
               if (sh_last) begin
                 sh_load    = we_q;
                 sh_ld_data = SW'(wdata_q);
                 sh_ld_cnt  = CNT_W'(WORD_W/8 - 1);
                 state_d    = we_q ? WDATA : TURN;
               end
             end
      WDATA: if (xfer) begin
               sh_shift = 1'b1;
               if (sh_last) state_d = RESP;
             end
      TURN:  begin
               sh_load   = 1'b1;
               sh_ld_cnt = CNT_W'(WORD_W/8 - 1);
               state_d   = RDATA;
             end
      RDATA: if (xfer) begin
               sh_cap = 1'b1;
               if (sh_last) state_d = RESP;
             end
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef RISCO5_IO_TIMEOUT_EN
    if (timeout) state_d = RESP;
`endif
  end
  risco5_io_shifter #(.W(SW)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .ld_data  (sh_ld_data),
    .ld_cnt   (sh_ld_cnt),
    .shift    (sh_shift),
    .capture  (sh_cap),
    .cap_byte (pad_in),
    .byte_out (sh_byte),
    .data     (sh_data),
    .last     (sh_last)
  );
  assign oe_on = state inside {CMD, ADDR, WDATA};
  assign pad_strobe = state inside {CMD, ADDR, WDATA, RDATA};
  assign pad_oe = oe_on ? PAD_OE_OUT : 8'h00;
  assign pad_out = state == CMD ? cmd_byte : oe_on ? sh_byte : 8'h00;
  assign busy = state != IDLE;
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_err = bus.rsp_valid && to_err;
  assign bus.rsp_rdata = (bus.rsp_valid && !we_q && !to_err) ? sh_data[SW-1 -: WORD_W] : '0;
endmodule

// File: tb/tb_risco5_io_bridge.sv
// tb_risco5_io_bridge: directed self-checking bench for risco5_io_bridge
module tb_risco5_io_bridge;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pad_out, pad_oe, pad_in;
  logic       pad_strobe, pad_ack, busy;
  int         errors = 0;
  int         checks = 0;
  risco5_io_bridge_if #(.ADDR_W(24), .WORD_W(32)) bus ();
  risco5_io_bridge #(.ADDR_W(24), .WORD_W(32), .TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .pad_out    (pad_out),
    .pad_oe     (pad_oe),
    .pad_in     (pad_in),
    .pad_strobe (pad_strobe),
    .pad_ack    (pad_ack),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic we, input logic [23:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    tick();
    bus.req_valid = 1'b0;
  endtask
  task automatic tx_bytes(input string tag, input int n, input logic [63:0] b);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_byte"}, 32'(pad_out), 32'(b[63-8*i -: 8]));
      chk({tag, "_oe"}, 32'(pad_oe), 32'hFF);
      chk({tag, "_strobe"}, 32'(pad_strobe), 32'd1);
      tick();
    end
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    pad_in = 8'h00;
    pad_ack = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_pad_out", 32'(pad_out), 32'd0);
    chk("rst_oe", 32'(pad_oe), 32'd0);
    chk("rst_strobe", 32'(pad_strobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    // write, ack tied high
    issue(1'b1, 24'h012345, 32'hDEADBEEF, 4'hF);
    chk("w_busy", 32'(busy), 32'd1);
    chk("w_ready", 32'(bus.req_ready), 32'd0);
    tx_bytes("w", 8, 64'h8F012345EFBEADDE);
    chk("w_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("w_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("w_rsp_rdata", bus.rsp_rdata, 32'd0);
    tick();
    chk("w_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    chk("w_idle_ready", 32'(bus.req_ready), 32'd1);
    // read with turnaround
    issue(1'b0, 24'h000010, 32'h0, 4'hF);
    tx_bytes("r", 4, 64'h0000001000000000);
    chk("r_turn_oe", 32'(pad_oe), 32'd0);
    chk("r_turn_strobe", 32'(pad_strobe), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      pad_in = 8'(8'h11 * (i + 1));
      chk("r_data_strobe", 32'(pad_strobe), 32'd1);
      chk("r_data_oe", 32'(pad_oe), 32'd0);
      chk("r_data_pad_out", 32'(pad_out), 32'd0);
      tick();
    end
    chk("r_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("r_rsp_rdata", bus.rsp_rdata, 32'h44332211);
    chk("r_rsp_err", 32'(bus.rsp_err), 32'd0);
    tick();
    // ack stall of 3 cycles on the second address byte
    begin
      logic [63:0] wb;
      int n;
      wb = 64'h8F012345EFBEADDE;
      n = 0;
      issue(1'b1, 24'h012345, 32'hDEADBEEF, 4'hF);
      for (int i = 0; i < 8; i++) begin
        if (i == 2) begin
          pad_ack = 1'b0;
          for (int s = 0; s < 3; s++) begin
            chk("s_hold", 32'(pad_out), 32'h23);
            tick();
            n++;
          end
          pad_ack = 1'b1;
        end
        chk("s_byte", 32'(pad_out), 32'(wb[63-8*i -: 8]));
        tick();
        n++;
      end
      chk("s_latency", 32'(n), 32'd11);
      chk("s_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("s_rsp_err", 32'(bus.rsp_err), 32'd0);
      tick();
    end
    // reset during WDATA byte 2
    issue(1'b1, 24'h012345, 32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 6; i++) tick();
    chk("x_wdata2", 32'(pad_out), 32'hAD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("x_strobe", 32'(pad_strobe), 32'd0);
    chk("x_oe", 32'(pad_oe), 32'd0);
    chk("x_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("x_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
`ifdef RISCO5_IO_TIMEOUT_EN
    // ack never arrives
    pad_ack = 1'b0;
    issue(1'b0, 24'h000010, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t_strobe", 32'(pad_strobe), 32'd1);
      chk("t_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    chk("t_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("t_rsp_rdata", bus.rsp_rdata, 32'd0);
    tick();
    // timeout after one captured read byte discards it
    pad_ack = 1'b1;
    pad_in = 8'h55;
    issue(1'b0, 24'h000010, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) tick();
    pad_ack = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t2_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("t2_rsp_rdata", bus.rsp_rdata, 32'd0);
    pad_ack = 1'b1;
    tick();
`else
    // without timeout the bridge waits for ack indefinitely
    pad_ack = 1'b0;
    issue(1'b0, 24'h000010, 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      chk("t_wait_strobe", 32'(pad_strobe), 32'd1);
      chk("t_wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    pad_ack = 1'b1;
    pad_in = 8'h5A;
    begin
      int k;
      k = 0;
      while (!bus.rsp_valid && k < 20) begin
        tick();
        k++;
      end
      chk("t_wait_done", 32'(bus.rsp_valid), 32'd1);
      chk("t_wait_err", 32'(bus.rsp_err), 32'd0);
      chk("t_wait_rdata", bus.rsp_rdata, 32'h5A5A5A5A);
    end
    tick();
`endif
    // back-to-back requests with req_valid held
    pad_ack = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 24'h012345;
    bus.req_wdata = 32'hDEADBEEF;
    bus.req_wstrb = 4'hF;
    tick();
    bus.req_addr = 24'hABCDEF;
    bus.req_wdata = 32'h01020304;
    bus.req_wstrb = 4'h3;
    tx_bytes("b1", 8, 64'h8F012345EFBEADDE);
    chk("b1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();
    chk("b_idle_ready", 32'(bus.req_ready), 32'd1);
    chk("b_idle_strobe", 32'(pad_strobe), 32'd0);
    tick();
    bus.req_valid = 1'b0;
    tx_bytes("b2", 8, 64'h83ABCDEF04030201);
    chk("b2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();
    chk("b_end_ready", 32'(bus.req_ready), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
